// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - serial sync-word frame transmitter
//
// Purpose:
//   Takes one parallel payload word over a valid/ready handshake.
//   Sends it one bit per clock as a frame: the sync word, then the payload.
//   Both parts go out MSB first. A fixed idle gap follows every frame.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   in_valid    payload available on in_data
//   in_data     payload word, DATA_W bits
//   in_ready    combinational, high only while idle
//   out_bit     registered serial bit, 0 whenever out_valid is low
//   out_valid   registered, high while out_bit carries a frame bit
//   sof         registered one-cycle pulse alongside the first sync bit
//   frame_done  registered one-cycle pulse alongside the last payload bit

module seq_frame_tx #(
  parameter int                 SYNC_W     = 4,
  parameter logic [SYNC_W-1:0]  SYNC       = 4'b1011,
  parameter int                 DATA_W     = 8,
  parameter int                 GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              sof,
  output logic              frame_done
);

  localparam int FW    = SYNC_W + DATA_W;
  localparam int MAX_A = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_B = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int MAXV  = (MAX_B > 1) ? MAX_B : 1;
  localparam int CW    = $clog2(MAXV) + 1;

  localparam logic [CW-1:0] SYNC_LOAD = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_LOAD = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC_ST = 2'd1,
    DATA_ST = 2'd2,
    GAP_ST = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [FW-1:0]   sr, sr_n;
  logic            out_bit_n, out_valid_n, sof_n, done_n;

  assign in_ready = (state == IDLE);

  // The sync word and payload share one shift register. The first sync bit
  // goes out on the handshake edge, so the register holds the frame already
  // shifted by one. Its MSB is always the next bit to send.
  // cnt counts the bits (or gap cycles) still left in the current state
  // after the one now on the line.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sr_n        = sr;
    out_bit_n   = 1'b0;
    out_valid_n = 1'b0;
    sof_n       = 1'b0;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (in_valid) begin
          state_n     = SYNC_ST;
          cnt_n       = SYNC_LOAD;
          sr_n        = {SYNC, in_data} << 1;
          out_bit_n   = SYNC[SYNC_W-1];
          out_valid_n = 1'b1;
          sof_n       = 1'b1;
        end
      end
      SYNC_ST: begin
        out_valid_n = 1'b1;
        out_bit_n   = sr[FW-1];
        sr_n        = sr << 1;
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = DATA_ST;
          cnt_n   = DATA_LOAD;
          done_n  = (DATA_W == 1);
        end
      end
      DATA_ST: begin
        if (cnt != '0) begin
          out_valid_n = 1'b1;
          out_bit_n   = sr[FW-1];
          sr_n        = sr << 1;
          cnt_n       = cnt - 1'b1;
          done_n      = (cnt == CW'(1));
        end else begin
          sr_n = '0;
          if (GAP_CYCLES > 0) begin
            state_n = GAP_ST;
            cnt_n   = GAP_LOAD;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
      end
      GAP_ST: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        sr_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      out_bit    <= 1'b0;
      out_valid  <= 1'b0;
      sof        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sr         <= sr_n;
      out_bit    <= out_bit_n;
      out_valid  <= out_valid_n;
      sof        <= sof_n;
      frame_done <= done_n;
    end
  end

endmodule
